// File: rtl/rat_ctrl_pkg.sv
// RAT flow-controller shared types.
// Op classes from the decoder and the controller state encoding.
package rat_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ALU   = 4'h1,
        OP_BRN   = 4'h2,
        OP_BREQ  = 4'h3,
        OP_BRNE  = 4'h4,
        OP_BRCS  = 4'h5,
        OP_BRCC  = 4'h6,
        OP_CALL  = 4'h7,
        OP_RET   = 4'h8,
        OP_RETID = 4'h9,
        OP_RETIE = 4'hA,
        OP_SEI   = 4'hB,
        OP_CLI   = 4'hC,
        OP_SEC   = 4'hD,
        OP_CLC   = 4'hE,
        OP_RSVD  = 4'hF
    } op_t;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_RETRD,
        ST_INTR
    } state_t;

    function automatic logic is_ret_op(input op_t op);
        return op inside {OP_RET, OP_RETID, OP_RETIE};
    endfunction

endpackage

// File: rtl/rat_stack_ptr.sv
// RAT hardware-stack pointer.
// Tracks SP, fill depth and a sticky over/underflow error.
module rat_stack_ptr #(
    parameter int SP_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    output logic [SP_W-1:0] sp,
    output logic            stk_err
);

    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);
    localparam logic [SP_W:0]   D_ONE  = (SP_W+1)'(1);
    localparam logic [SP_W:0]   D_FULL = {1'b1, {SP_W{1'b0}}};

    logic [SP_W:0] depth;

    // SP always moves; depth saturates and flags the error instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp      <= '0;
            depth   <= '0;
            stk_err <= 1'b0;
        end else if (push) begin
            sp <= sp - SP_ONE;
            if (depth == D_FULL) stk_err <= 1'b1;
            else                 depth   <= depth + D_ONE;
        end else if (pop) begin
            sp <= sp + SP_ONE;
            if (depth == '0) stk_err <= 1'b1;
            else             depth   <= depth - D_ONE;
        end
    end

endmodule

// File: rtl/rat_flow_ctrl.sv
// RAT program-flow controller.
// PC, CALL/RET stack in scratch RAM, flags and interrupt entry.
module rat_flow_ctrl
    import rat_ctrl_pkg::*;
#(
    parameter int              PC_W    = 10,
    parameter int              SP_W    = 8,
    parameter logic [PC_W-1:0] INT_VEC = {PC_W{1'b1}}
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            INT,
    input  logic [3:0]      IR_OP,
    input  logic [PC_W-1:0] IR_ADDR,
    input  logic            C_IN,
    input  logic            Z_IN,
    input  logic [PC_W-1:0] SCR_DIN,
    output logic [PC_W-1:0] PC,
    output logic            FETCH,
    output logic            EXEC,
    output logic [SP_W-1:0] SCR_ADDR,
    output logic            SCR_WE,
    output logic [PC_W-1:0] SCR_DOUT,
    output logic            C_FLAG,
    output logic            Z_FLAG,
    output logic            IE,
    output logic            STK_ERR
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

    op_t             op;
    op_t             ret_op;
    state_t          state;
    state_t          nstate;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc;
    logic [SP_W-1:0] sp;
    logic            c_q, z_q, ie_q;
    logic            sh_c, sh_z;
    logic            pend;
    logic            go_intr;
    logic            take;
    logic            push, pop;

    assign op     = op_t'(IR_OP);
    assign pc_inc = pc_q + PC_ONE;

    rat_stack_ptr #(.SP_W(SP_W)) u_sp (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .push    (push),
        .pop     (pop),
        .sp      (sp),
        .stk_err (STK_ERR)
    );

    // Controller state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_FETCH;
        else          state <= nstate;
    end

    // Next state, stack strobes and scratch-port drive.
    always_comb begin
        nstate   = ST_FETCH;
        go_intr  = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        SCR_WE   = 1'b0;
        SCR_ADDR = sp;
        SCR_DOUT = pc_inc;
        unique case (state)
            ST_FETCH: nstate = ST_EXEC;
            ST_EXEC: begin
                if (is_ret_op(op)) begin
                    nstate = ST_RETRD;
                end else if (ie_q && pend) begin
                    nstate  = ST_INTR;
                    go_intr = 1'b1;
                end
                if (op == OP_CALL) begin
                    push     = 1'b1;
                    SCR_WE   = 1'b1;
                    SCR_ADDR = sp - SP_ONE;
                end
            end
            ST_RETRD: pop = 1'b1;
            ST_INTR: begin
                push     = 1'b1;
                SCR_WE   = 1'b1;
                SCR_ADDR = sp - SP_ONE;
                SCR_DOUT = pc_q;
            end
            default: nstate = ST_FETCH;
        endcase
    end

    // Branch-taken decision from the registered flags.
    always_comb begin
        take = 1'b0;
        unique case (op)
            OP_BRN:  take = 1'b1;
            OP_BREQ: take = z_q;
            OP_BRNE: take = !z_q;
            OP_BRCS: take = c_q;
            OP_BRCC: take = !c_q;
            OP_CALL: take = 1'b1;
            default: take = 1'b0;
        endcase
    end

    // Interrupt latch: a new request wins over the entry clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) pend <= 1'b0;
        else          pend <= INT | (pend & ~go_intr);
    end

    // PC, flags, interrupt enable and shadow flags.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q   <= '0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            ie_q   <= 1'b0;
            sh_c   <= 1'b0;
            sh_z   <= 1'b0;
            ret_op <= OP_RET;
        end else begin
            unique case (state)
                ST_EXEC: begin
                    if (!is_ret_op(op))
                        pc_q <= take ? IR_ADDR : pc_inc;
                    else
                        ret_op <= op;
                    unique case (op)
                        OP_ALU: begin
                            c_q <= C_IN;
                            z_q <= Z_IN;
                        end
                        OP_SEI:  ie_q <= 1'b1;
                        OP_CLI:  ie_q <= 1'b0;
                        OP_SEC:  c_q  <= 1'b1;
                        OP_CLC:  c_q  <= 1'b0;
                        default: ;
                    endcase
                end
                ST_RETRD: begin
                    pc_q <= SCR_DIN;
                    if (ret_op != OP_RET) begin
                        c_q  <= sh_c;
                        z_q  <= sh_z;
                        ie_q <= (ret_op == OP_RETIE);
                    end
                end
                ST_INTR: begin
                    sh_c <= c_q;
                    sh_z <= z_q;
                    c_q  <= 1'b0;
                    z_q  <= 1'b0;
                    ie_q <= 1'b0;
                    pc_q <= INT_VEC;
                end
                default: ;
            endcase
        end
    end

    assign PC     = pc_q;
    assign FETCH  = (state == ST_FETCH);
    assign EXEC   = (state == ST_EXEC);
    assign C_FLAG = c_q;
    assign Z_FLAG = z_q;
    assign IE     = ie_q;

endmodule

// File: tb/tb_rat_flow_ctrl.sv
// Self-checking bench for rat_flow_ctrl.
// Instruction-level model plus a small-stack instance.
module tb_rat_flow_ctrl;

    localparam logic [3:0] NOP = 4'h0, ALU = 4'h1, BRN = 4'h2;
    localparam logic [3:0] BREQ = 4'h3, BRNE = 4'h4;
    localparam logic [3:0] BRCS = 4'h5, BRCC = 4'h6, CALL = 4'h7;
    localparam logic [3:0] RET = 4'h8, RETID = 4'h9, RETIE = 4'hA;
    localparam logic [3:0] SEI = 4'hB, CLI = 4'hC;
    localparam logic [3:0] SEC = 4'hD, CLC = 4'hE;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       INT = 1'b0;
    logic [3:0] IR_OP = 4'hF;
    logic [9:0] IR_ADDR = '0;
    logic       C_IN = 1'b0, Z_IN = 1'b0;
    logic [9:0] SCR_DIN;
    logic [9:0] PC, SCR_DOUT;
    logic       FETCH, EXEC, SCR_WE;
    logic [7:0] SCR_ADDR;
    logic       C_FLAG, Z_FLAG, IE, STK_ERR;

    logic       s_rst_n = 1'b0;
    logic [3:0] s_op = 4'h0;
    logic [9:0] s_addr = 10'h010;
    logic [9:0] s_din, s_pc, s_dout;
    logic       s_fetch, s_exec, s_we;
    logic [1:0] s_saddr;
    logic       s_c, s_z, s_ie, s_err;

    int n_err = 0;
    int n_chk = 0;

    always #5 CLK = ~CLK;

    rat_flow_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .INT(INT),
        .IR_OP(IR_OP), .IR_ADDR(IR_ADDR),
        .C_IN(C_IN), .Z_IN(Z_IN), .SCR_DIN(SCR_DIN),
        .PC(PC), .FETCH(FETCH), .EXEC(EXEC),
        .SCR_ADDR(SCR_ADDR), .SCR_WE(SCR_WE),
        .SCR_DOUT(SCR_DOUT), .C_FLAG(C_FLAG),
        .Z_FLAG(Z_FLAG), .IE(IE), .STK_ERR(STK_ERR)
    );

    rat_flow_ctrl #(.SP_W(2)) dut_s (
        .CLK(CLK), .RESET_N(s_rst_n), .INT(1'b0),
        .IR_OP(s_op), .IR_ADDR(s_addr),
        .C_IN(1'b0), .Z_IN(1'b0), .SCR_DIN(s_din),
        .PC(s_pc), .FETCH(s_fetch), .EXEC(s_exec),
        .SCR_ADDR(s_saddr), .SCR_WE(s_we),
        .SCR_DOUT(s_dout), .C_FLAG(s_c),
        .Z_FLAG(s_z), .IE(s_ie), .STK_ERR(s_err)
    );

    // Scratch RAMs with one-cycle read latency.
    logic [9:0] ram [256];
    logic [9:0] sram [4];
    always @(posedge CLK) begin
        if (SCR_WE) ram[SCR_ADDR] <= SCR_DOUT;
        SCR_DIN <= ram[SCR_ADDR];
        if (s_we) sram[s_saddr] <= s_dout;
        s_din <= sram[s_saddr];
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // Architectural model.
    logic [9:0] m_pc;
    logic [7:0] m_sp;
    int         m_depth;
    logic       m_c, m_z, m_ie, m_sh_c, m_sh_z;
    logic       m_err, m_pend;
    logic [9:0] m_mem [256];

    task automatic model_reset();
        m_pc = '0; m_sp = '0; m_depth = 0;
        m_c = 0; m_z = 0; m_ie = 0;
        m_sh_c = 0; m_sh_z = 0;
        m_err = 0; m_pend = 0;
    endtask

    task automatic m_push(input logic [9:0] v);
        m_sp = m_sp - 8'd1;
        m_mem[m_sp] = v;
        if (m_depth == 256) m_err = 1;
        else m_depth++;
    endtask

    task automatic m_pop(output logic [9:0] v);
        v = m_mem[m_sp];
        m_sp = m_sp + 8'd1;
        if (m_depth == 0) m_err = 1;
        else m_depth--;
    endtask

    // Expected outputs for the current cycle.
    logic       chk_en = 1'b0;
    logic       e_f, e_e, e_we, e_ca, e_c, e_z, e_ie, e_err;
    logic [7:0] e_a;
    logic [9:0] e_d, e_pc;

    task automatic set_exp(input bit f, input bit e,
                           input bit we, input bit ca,
                           input logic [7:0] a,
                           input logic [9:0] d);
        e_f = f; e_e = e; e_we = we; e_ca = ca;
        e_a = a; e_d = d;
        e_pc = m_pc; e_c = m_c; e_z = m_z;
        e_ie = m_ie; e_err = m_err;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("pc", 32'(PC), 32'(e_pc));
            chk("fetch", 32'(FETCH), 32'(e_f));
            chk("exec", 32'(EXEC), 32'(e_e));
            chk("scr_we", 32'(SCR_WE), 32'(e_we));
            chk("c_flag", 32'(C_FLAG), 32'(e_c));
            chk("z_flag", 32'(Z_FLAG), 32'(e_z));
            chk("ie", 32'(IE), 32'(e_ie));
            chk("stk_err", 32'(STK_ERR), 32'(e_err));
            if (e_ca)
                chk("scr_addr", 32'(SCR_ADDR), 32'(e_a));
            if (e_we)
                chk("scr_dout", 32'(SCR_DOUT), 32'(e_d));
        end
    end

    // One instruction: FETCH, EXEC and RETRD or INTR if any.
    task automatic do_instr(input logic [3:0] op,
                            input logic [9:0] tgt,
                            input bit cin, input bit zin,
                            input bit ir, input bit rst_intr);
        bit         is_ret, is_call, go;
        logic [9:0] npc, v;
        INT = 0; IR_OP = 4'hF; IR_ADDR = '0;
        C_IN = 0; Z_IN = 0;
        set_exp(1, 0, 0, 0, '0, '0);
        @(posedge CLK); #1;
        is_ret  = op inside {RET, RETID, RETIE};
        is_call = (op == CALL);
        go = !is_ret && m_ie && m_pend;
        IR_OP = op; IR_ADDR = tgt;
        C_IN = cin; Z_IN = zin; INT = ir;
        set_exp(0, 1, is_call, is_call || is_ret,
                is_call ? 8'(m_sp - 8'd1) : m_sp,
                10'(m_pc + 10'd1));
        @(posedge CLK); #1;
        npc = 10'(m_pc + 10'd1);
        case (op)
            ALU:  begin m_c = cin; m_z = zin; end
            BRN:  npc = tgt;
            BREQ: if (m_z) npc = tgt;
            BRNE: if (!m_z) npc = tgt;
            BRCS: if (m_c) npc = tgt;
            BRCC: if (!m_c) npc = tgt;
            CALL: begin m_push(npc); npc = tgt; end
            RET, RETID, RETIE: npc = m_pc;
            SEI:  m_ie = 1;
            CLI:  m_ie = 0;
            SEC:  m_c = 1;
            CLC:  m_c = 0;
            default: ;
        endcase
        m_pc = npc;
        m_pend = go ? ir : (m_pend | ir);
        INT = 0; IR_OP = 4'hF;
        if (is_ret) begin
            set_exp(0, 0, 0, 0, '0, '0);
            @(posedge CLK); #1;
            m_pop(v);
            m_pc = v;
            if (op != RET) begin
                m_c = m_sh_c; m_z = m_sh_z;
                m_ie = (op == RETIE);
            end
        end else if (go) begin
            set_exp(0, 0, 1, 1, 8'(m_sp - 8'd1), m_pc);
            if (rst_intr) begin
                #2; RESET_N = 0; #1;
                chk("rst_pc", 32'(PC), 32'h0);
                chk("rst_we", 32'(SCR_WE), 32'h0);
                chk("rst_fetch", 32'(FETCH), 32'h1);
                model_reset();
                set_exp(1, 0, 0, 0, '0, '0);
                @(posedge CLK); #1;
                RESET_N = 1;
            end else begin
                @(posedge CLK); #1;
                m_push(m_pc);
                m_sh_c = m_c; m_sh_z = m_z;
                m_c = 0; m_z = 0; m_ie = 0;
                m_pc = 10'h3FF;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #3;
        chk("reset_pc", 32'(PC), 32'h0);
        chk("reset_fetch", 32'(FETCH), 32'h1);
        chk("reset_exec", 32'(EXEC), 32'h0);
        chk("reset_we", 32'(SCR_WE), 32'h0);
        chk("reset_flags", {IE, C_FLAG, Z_FLAG, STK_ERR}, 32'h0);
        @(posedge CLK); #1;
        RESET_N = 1;
        chk_en = 1;

        repeat (4) do_instr(NOP, '0, 0, 0, 0, 0);
        chk("lit_nop_pc", 32'(PC), 32'h004);
        do_instr(ALU, '0, 1, 0, 0, 0);
        chk("lit_alu_c", 32'(C_FLAG), 32'h1);
        do_instr(BRCS, 10'h055, 0, 0, 0, 0);
        chk("lit_brcs", 32'(PC), 32'h055);
        do_instr(BREQ, 10'h100, 0, 0, 0, 0);
        chk("lit_breq", 32'(PC), 32'h056);
        do_instr(BRNE, 10'h080, 0, 0, 0, 0);
        do_instr(ALU, '0, 0, 1, 0, 0);
        do_instr(BRCC, 10'h010, 0, 0, 0, 0);
        chk("lit_brcc", 32'(PC), 32'h010);
        do_instr(CALL, 10'h200, 0, 0, 0, 0);
        chk("lit_call_pc", 32'(PC), 32'h200);
        chk("lit_call_ram", 32'(ram[8'hFF]), 32'h011);
        do_instr(RET, '0, 0, 0, 0, 0);
        chk("lit_ret_pc", 32'(PC), 32'h011);

        do_instr(SEI, '0, 0, 0, 0, 0);
        do_instr(SEC, '0, 0, 0, 0, 0);
        do_instr(NOP, '0, 0, 0, 1, 0);
        do_instr(NOP, '0, 0, 0, 0, 0);
        chk("lit_intr_pc", 32'(PC), 32'h3FF);
        chk("lit_intr_c", 32'(C_FLAG), 32'h0);
        chk("lit_intr_ie", 32'(IE), 32'h0);
        chk("lit_intr_ram", 32'(ram[8'hFF]), 32'h015);
        do_instr(RETIE, '0, 0, 0, 0, 0);
        chk("lit_retie_pc", 32'(PC), 32'h015);
        chk("lit_retie_c", 32'(C_FLAG), 32'h1);
        chk("lit_retie_ie", 32'(IE), 32'h1);

        do_instr(NOP, '0, 0, 0, 1, 0);
        do_instr(CLI, '0, 0, 0, 0, 0);
        chk("lit_cli_intr", 32'(PC), 32'h3FF);
        do_instr(RETID, '0, 0, 0, 0, 0);
        chk("lit_retid_pc", 32'(PC), 32'h017);
        chk("lit_retid_ie", 32'(IE), 32'h0);
        do_instr(CLC, '0, 0, 0, 0, 0);
        do_instr(BRN, 10'h3FF, 0, 0, 0, 0);
        do_instr(NOP, '0, 0, 0, 0, 0);
        chk("lit_pc_wrap", 32'(PC), 32'h000);

        do_instr(SEI, '0, 0, 0, 0, 0);
        do_instr(NOP, '0, 0, 0, 1, 0);
        do_instr(NOP, '0, 0, 0, 0, 1);
        do_instr(CALL, 10'h123, 0, 0, 0, 0);
        chk("lit_post_rst_ram", 32'(ram[8'hFF]), 32'h001);
        do_instr(RET, '0, 0, 0, 0, 0);
        chk("lit_post_rst_pc", 32'(PC), 32'h001);
        @(negedge CLK);
        chk_en = 0;

        // Small stack: 4 calls fill it, the 5th overflows.
        s_op = CALL;
        @(negedge CLK); s_rst_n = 1;
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        chk("s_err_full", 32'(s_err), 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("s_err_ovf", 32'(s_err), 32'h1);
        s_rst_n = 0; #1;
        chk("s_err_reset", 32'(s_err), 32'h0);
        s_op = RET;
        @(negedge CLK); s_rst_n = 1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("s_err_udf", 32'(s_err), 32'h1);
        @(posedge CLK);
        @(negedge CLK);
        chk("s_exec", 32'(s_exec), 32'h1);
        chk("s_sp_wrap", 32'(s_saddr), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
